// File: rtl/cpu_pkg.sv
// Shared definitions for the GCD CPU: word size, NOP encoding, instruction
// memory depth and the program-loader state encoding.
package cpu_pkg;

    localparam int          WORD_W     = 32;
    localparam logic [31:0] NOP_INSTR  = 32'd0;
    localparam int          IMEM_DEPTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream into big-endian 32-bit words. Flags a full word on its
// 4th byte and a zero-padded partial word when the stream ends mid-word.
module imem_loader_word_assembler
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic [WORD_W-1:0] word,
    output logic              word_complete,
    output logic              word_partial
);

    logic [23:0] shift_r;
    logic [1:0]  count_r;

    // Place the incoming byte behind the bytes already held, padding low bytes with zero.
    always_comb begin
        word = {shift_r, byte_data};
        case (count_r)
            2'd0:    word = {byte_data, 24'd0};
            2'd1:    word = {shift_r[7:0], byte_data, 16'd0};
            2'd2:    word = {shift_r[15:0], byte_data, 8'd0};
            2'd3:    word = {shift_r, byte_data};
            default: word = {shift_r, byte_data};
        endcase
    end

    assign word_complete = byte_en && (count_r == 2'd3);
    assign word_partial  = byte_en && byte_last && (count_r != 2'd3);

    // Byte shift register and position counter; a finished or truncated word restarts the group.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_r <= 24'd0;
            count_r <= 2'd0;
        end else if (byte_en) begin
            if ((count_r == 2'd3) || byte_last) begin
                shift_r <= 24'd0;
                count_r <= 2'd0;
            end else begin
                shift_r <= {shift_r[15:0], byte_data};
                count_r <= count_r + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader on the write side and
// a one-cycle registered fetch port; the CPU is held in reset while loading.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    input  logic [WORD_W-1:0] fetch_addr,
    output logic [WORD_W-1:0] instr
);

    localparam logic [ADDR_W:0] FULL_WPTR = (ADDR_W + 1)'(DEPTH);

    load_state_t       state_r;
    logic [ADDR_W:0]   wptr_r;
    logic [WORD_W-1:0] mem_r [DEPTH];

    logic              accept_s;
    logic              asm_clear_s;
    logic              word_complete_s;
    logic              word_partial_s;
    logic              word_ready_s;
    logic              mem_we_s;
    logic              hold_next_s;
    logic [WORD_W-1:0] asm_word_s;
    logic              unused_addr_bits;

    assign accept_s     = in_valid && in_ready;
    assign asm_clear_s  = (state_r == IDLE) && load_req;
    assign word_ready_s = accept_s && (word_complete_s || word_partial_s);
    assign mem_we_s     = word_ready_s && (wptr_r != FULL_WPTR);
    assign words_loaded = wptr_r;

    assign unused_addr_bits = ^{fetch_addr[WORD_W-1:ADDR_W+2], fetch_addr[1:0]};

    imem_loader_word_assembler u_asm (
        .clk           (clk),
        .rst           (rst),
        .clear         (asm_clear_s),
        .byte_en       (accept_s),
        .byte_data     (in_data),
        .byte_last     (in_last),
        .word          (asm_word_s),
        .word_complete (word_complete_s),
        .word_partial  (word_partial_s)
    );

    // Next value of cpu_hold, shared with the read port so instr is NOP for the whole hold window.
    always_comb begin
        hold_next_s = cpu_hold;
        if (rst) begin
            hold_next_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    hold_next_s = load_req ? 1'b1 : cpu_hold;
                LOAD:    hold_next_s = cpu_hold;
                DONE:    hold_next_s = 1'b0;
                default: hold_next_s = 1'b0;
            endcase
        end
    end

    // Loader FSM with registered handshake, status and write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            in_ready  <= 1'b0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            wptr_r    <= '0;
        end else begin
            cpu_hold <= hold_next_s;
            case (state_r)
                IDLE: begin
                    load_done <= 1'b0;
                    if (load_req) begin
                        state_r  <= LOAD;
                        in_ready <= 1'b1;
                        load_err <= 1'b0;
                        wptr_r   <= '0;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        // Words beyond the array are dropped; the count saturates at DEPTH.
                        if (word_ready_s) begin
                            if (wptr_r == FULL_WPTR) begin
                                load_err <= 1'b1;
                            end else begin
                                wptr_r <= wptr_r + 1'b1;
                            end
                            if (word_partial_s) begin
                                load_err <= 1'b1;
                            end
                        end
                        if (in_last) begin
                            state_r   <= DONE;
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    load_done <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b0;
                    load_done <= 1'b0;
                end
            endcase
        end
    end

    // Instruction array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wptr_r[ADDR_W-1:0]] <= asm_word_s;
        end
    end

    // Fetch port: word-indexed, wraps modulo DEPTH, NOP while the CPU is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= NOP_INSTR;
        end else if (hold_next_s) begin
            instr <= NOP_INSTR;
        end else begin
            instr <= mem_r[fetch_addr[ADDR_W+1:2]];
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-queue model of the loader and memory
// is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, load_req, in_valid, in_last;
    logic [7:0]  in_data;
    logic        in_ready, cpu_hold, load_done, load_err;
    logic [7:0]  words_loaded;
    logic [31:0] fetch_addr, instr;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(128), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded), .fetch_addr(fetch_addr), .instr(instr)
    );

    int checks = 0;
    int passes = 0;

    // Model: memory image, phase (0 idle, 1 loading, 2 finishing), current byte group.
    logic [31:0] mem_m [128];
    bit          memv_m [128];
    int          phase_m = 0;
    int          nbytes_m = 0;
    logic [7:0]  grp[$];

    bit          armed = 1'b0;
    bit          e_ready = 1'b0, e_hold = 1'b0, e_done = 1'b0, e_err = 1'b0;
    int          e_wl = 0;
    logic [31:0] e_instr = 32'd0;
    bit          e_instr_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock: advance the model from the inputs present at this edge.
    task automatic tick();
        int          a;
        int          widx;
        logic [31:0] rd;
        logic [31:0] w;
        bit          rdv;
        bit          n_ready, n_hold, n_done, n_err;
        int          n_wl;
        a = int'(fetch_addr[8:2]);
        rd = mem_m[a];
        rdv = memv_m[a];
        n_ready = e_ready; n_hold = e_hold; n_done = 1'b0; n_err = e_err; n_wl = e_wl;
        if (rst) begin
            phase_m = 0; n_ready = 0; n_hold = 0; n_err = 0; n_wl = 0;
            nbytes_m = 0; grp.delete();
        end else if (phase_m == 0) begin
            if (load_req) begin
                phase_m = 1; n_ready = 1; n_hold = 1; n_err = 0; n_wl = 0;
                nbytes_m = 0; grp.delete();
            end
        end else if (phase_m == 1) begin
            if (in_valid) begin
                grp.push_back(in_data);
                nbytes_m++;
                if (grp.size() == 4 || in_last) begin
                    widx = (nbytes_m - 1) / 4;
                    w = 32'd0;
                    for (int k = 0; k < grp.size(); k++) w[31-8*k -: 8] = grp[k];
                    if (widx < 128) begin
                        mem_m[widx] = w;
                        memv_m[widx] = 1'b1;
                    end else begin
                        n_err = 1'b1;
                    end
                    n_wl = (widx + 1 > 128) ? 128 : widx + 1;
                    if (grp.size() != 4) n_err = 1'b1;
                    grp.delete();
                end
                if (in_last) begin
                    phase_m = 2; n_ready = 0; n_done = 1;
                end
            end
        end else begin
            phase_m = 0; n_hold = 0;
        end
        @(posedge clk);
        #1;
        e_ready = n_ready; e_hold = n_hold; e_done = n_done; e_err = n_err; e_wl = n_wl;
        e_instr = (rst || n_hold) ? 32'd0 : rd;
        e_instr_known = rst || n_hold || rdv;
    endtask

    // Compare process: all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
            chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, e_hold});
            chk("load_done", {31'd0, load_done}, {31'd0, e_done});
            chk("load_err", {31'd0, load_err}, {31'd0, e_err});
            chk("words_loaded", {24'd0, words_loaded}, e_wl);
            if (e_instr_known) chk("instr", instr, e_instr);
        end
    end

    task automatic send_prog(input logic [7:0] bytes[$], input bit with_last);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("hold_on_req", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < bytes.size(); i++) begin
            in_valid = 1'b1;
            in_data  = bytes[i];
            in_last  = with_last && (i == bytes.size() - 1);
            fetch_addr = 32'(i * 4);
            tick();
            if (i == 0) chk("instr_nop_hold", instr, 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        fetch_addr = 32'd0;
        if (with_last) begin
            chk("done_pulse", {31'd0, load_done}, 32'd1);
            chk("hold_in_done", {31'd0, cpu_hold}, 32'd1);
            tick();
            chk("done_cleared", {31'd0, load_done}, 32'd0);
            chk("hold_dropped", {31'd0, cpu_hold}, 32'd0);
        end
    endtask

    task automatic fetch(input logic [31:0] addr);
        fetch_addr = addr;
        tick();
    endtask

    initial begin
        logic [7:0] q[$];
        rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = 8'd0; fetch_addr = 32'd0;
        for (int i = 0; i < 128; i++) memv_m[i] = 1'b0;
        tick();
        armed = 1'b1;
        load_req = 1'b1;
        tick();
        rst = 1'b0;
        load_req = 1'b0;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        tick();

        // Two-word program.
        q = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h20, 8'h01, 8'h00, 8'h05};
        send_prog(q, 1'b1);
        chk("p1_words", {24'd0, words_loaded}, 32'd2);
        chk("p1_err", {31'd0, load_err}, 32'd0);
        fetch(32'd0);
        chk("p1_mem0", instr, 32'h0000_0008);
        fetch(32'd4);
        chk("p1_mem1", instr, 32'h2001_0005);
        fetch(32'd8);

        // Partial last word, with a stray load_req during the load.
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load_req = 1'b1;
        tick();
        chk("p2_started", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = q[i];
            in_last = (i == 5);
            tick();
            load_req = 1'b0;
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        chk("p2_words", {24'd0, words_loaded}, 32'd2);
        chk("p2_err", {31'd0, load_err}, 32'd1);
        fetch(32'd4);
        chk("p2_mem1", instr, 32'h1122_0000);
        fetch(32'd0);
        chk("p2_mem0", instr, 32'hAABB_CCDD);

        // Overflow: 129 words.
        q.delete();
        for (int i = 0; i < 516; i++) q.push_back(8'((i * 7 + 3) & 255));
        send_prog(q, 1'b1);
        chk("ov_words", {24'd0, words_loaded}, 32'd128);
        chk("ov_err", {31'd0, load_err}, 32'd1);
        fetch(32'd0);
        chk("ov_mem0", instr, 32'h030A_1118);
        fetch(32'h0000_0204);
        chk("ov_wrap", instr, 32'h1F26_2D34);
        fetch(32'd508);
        fetch(32'd8);
        fetch(32'hFFFF_FE03);

        // Reset after 3 words plus 2 bytes.
        q.delete();
        for (int i = 0; i < 14; i++) q.push_back(8'(8'h40 + i));
        send_prog(q, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_hold", {31'd0, cpu_hold}, 32'd0);
        chk("mr_ready", {31'd0, in_ready}, 32'd0);
        fetch(32'd0);
        chk("mr_mem0", instr, 32'h4041_4243);
        fetch(32'd8);
        chk("mr_mem2", instr, 32'h4849_4A4B);
        fetch(32'd12);

        // Reload restarts at word 0 with a clean error flag.
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_prog(q, 1'b1);
        chk("rl_err", {31'd0, load_err}, 32'd0);
        chk("rl_words", {24'd0, words_loaded}, 32'd1);
        fetch(32'd0);
        chk("rl_mem0", instr, 32'hDEAD_BEEF);
        fetch(32'd4);
        tick();

        armed = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
